// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART TX arbiter.
// slave modport is the arbiter's view; master modport is the environment's view.
// Requester k uses byte lane [8k+7:8k] of i_req_byte.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // requester side
  logic [N_REQ-1:0]   i_req_valid;
  logic [8*N_REQ-1:0] i_req_byte;
  logic [N_REQ-1:0]   i_req_last;
  logic [N_REQ-1:0]   o_req_ready;

  // transmitter side
  logic               o_tx_dv;
  logic [7:0]         o_tx_byte;
  logic               i_tx_active;
  logic               i_tx_done;

  // status
  logic [GW-1:0]      o_grant_id;
  logic               o_busy;
  logic               o_err_timeout;

  modport slave (
    input  i_req_valid, i_req_byte, i_req_last, i_tx_active, i_tx_done,
    output o_req_ready, o_tx_dv, o_tx_byte, o_grant_id, o_busy, o_err_timeout
  );

  modport master (
    output i_req_valid, i_req_byte, i_req_last, i_tx_active, i_tx_done,
    input  o_req_ready, o_tx_dv, o_tx_byte, o_grant_id, o_busy, o_err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from N_REQ requesters into one UART TX, with frame lock.
// Latency: ready/dv/byte appear one cycle after the grant edge; all outputs are registered.
// Backpressure: no grant while the transmitter is active or a byte is in flight (waits for tx_done).
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input logic              i_clk,
  input logic              i_rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (HOLD_TIMEOUT < 2) ? 1 : $clog2(HOLD_TIMEOUT + 1);
  // Value of the timeout counter on the cycle that completes the idle window.
  localparam logic [TW-1:0] TMO_LAST = TW'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_HOLD      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic               last_q, last_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic               dv_q, dv_d;
  logic [7:0]         byte_q, byte_d;
  logic [GW-1:0]      gid_q, gid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               rr_found;
  logic [GW-1:0]      rr_idx;
  int                 cand;
  logic [GW-1:0]      sel_idx;
  logic [7:0]         sel_byte;
  logic               sel_last;
  logic               grant;

  // Round-robin search: first valid requester starting just after the last winner, with wrap.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!rr_found && bus.i_req_valid[cand[GW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[GW-1:0];
      end
    end
  end

  // While a frame is locked only the holder may be served, so the data mux follows it.
  assign sel_idx = (state_q == ST_HOLD) ? gid_q : rr_idx;

  // Byte/last mux for the requester being considered this cycle.
  always_comb begin
    sel_byte = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_idx == GW'(k)) begin
        sel_byte = bus.i_req_byte[8*k +: 8];
        sel_last = bus.i_req_last[k];
      end
    end
  end

  // Next-state and registered-output logic; pulses default low and fire for one cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    ready_d = '0;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    gid_d   = gid_q;
    err_d   = 1'b0;
    grant   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rr_found && !bus.i_tx_active) begin
          grant = 1'b1;
          ptr_d = rr_idx;
        end
      end

      ST_WAIT_DONE: begin
        if (bus.i_tx_done) begin
          if (last_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            tmo_d   = '0;
          end
        end
      end

      ST_HOLD: begin
        if (bus.i_req_valid[gid_q]) begin
          // Locked requester continues its frame; pointer stays on it.
          grant = 1'b1;
        end else if (HOLD_TIMEOUT != 0) begin
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (grant) begin
      ready_d[sel_idx] = 1'b1;
      dv_d             = 1'b1;
      byte_d           = sel_byte;
      gid_d            = sel_idx;
      last_d           = sel_last;
      state_d          = ST_WAIT_DONE;
    end
  end

  // Busy mirrors the state that will be held after this edge.
  assign busy_d = (state_d != ST_IDLE);

  // State and output registers; reset abandons any frame lock and restores requester 0 priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= GW'(N_REQ - 1);
      last_q  <= 1'b0;
      tmo_q   <= '0;
      ready_q <= '0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      ready_q <= ready_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_req_ready   = ready_q;
  assign bus.o_tx_dv       = dv_q;
  assign bus.o_tx_byte     = byte_q;
  assign bus.o_grant_id    = gid_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a simple UART TX model and a grant scoreboard.
// Expected (requester, byte) pairs are queued as stimulus is pushed and matched at each tx_dv.
// Timeout, busy guard and mid-transfer reset are checked against cycle stamps.
module tb_uart_tx_arbiter;

  localparam int N_REQ  = 4;
  localparam int HT     = 8;
  localparam int TX_LEN = 6;

  typedef struct packed {
    logic [7:0] byt;
    logic       last;
  } rq_t;

  typedef struct {
    int         id;
    logic [7:0] byt;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  always #5 i_clk = ~i_clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(
    .N_REQ       (N_REQ),
    .HOLD_TIMEOUT(HT)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  logic [N_REQ-1:0]   req_valid_v  = '0;
  logic [N_REQ-1:0]   req_last_v   = '0;
  logic [8*N_REQ-1:0] req_byte_v   = '0;
  logic               model_active = 1'b0;
  logic               model_done   = 1'b0;
  logic               force_active = 1'b0;
  logic               man_done     = 1'b0;
  logic               tx_auto      = 1'b1;

  assign bus.i_req_valid = req_valid_v;
  assign bus.i_req_byte  = req_byte_v;
  assign bus.i_req_last  = req_last_v;
  assign bus.i_tx_active = model_active | force_active;
  assign bus.i_tx_done   = model_done | man_done;

  rq_t  rq [N_REQ][$];
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int dv_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int err_cyc = 0;
  int err_gap = 0;
  int last_dv_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [7:0] b, input logic last);
    rq_t  r;
    exp_t e;
    r.byt  = b;
    r.last = last;
    rq[id].push_back(r);
    e.id  = id;
    e.byt = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  function automatic bit rq_pending();
    bit p = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (rq[k].size() != 0) p = 1'b1;
    end
    return p;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rq_pending() || bus.o_busy || tx_cnt != 0 || model_done) && n < 2000) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    check_eq({tag, "_drained"}, 32'(n < 2000), 1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    wait_cycles(2);
    i_rst = 1'b0;
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Output monitor, transmitter model and requester drivers, all evaluated mid-cycle.
  always @(negedge i_clk) begin : neg_blk
    exp_t e;
    if (bus.o_tx_dv) begin
      dv_cnt++;
      last_dv_cyc = cyc;
      check_eq("dv_gap", 32'(tx_cnt == 0 && !model_done), 1);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_dv", 32'(bus.o_tx_byte), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("tx_byte", 32'(bus.o_tx_byte), 32'(e.byt));
        check_eq("grant_id", 32'(bus.o_grant_id), 32'(e.id));
        check_eq("ready_onehot", 32'(bus.o_req_ready), 32'(1) << e.id);
        check_eq("busy_at_dv", 32'(bus.o_busy), 1);
      end
    end else if (bus.o_req_ready != '0) begin
      check_eq("ready_without_dv", 32'(bus.o_req_ready), 0);
    end

    if (bus.o_err_timeout) begin
      err_cnt++;
      err_gap = cyc - done_cyc;
      err_cyc = cyc;
    end

    model_done = 1'b0;
    if (bus.o_tx_dv && tx_auto) begin
      tx_cnt       = TX_LEN;
      model_active = 1'b1;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        model_active = 1'b0;
        model_done   = 1'b1;
        done_cyc     = cyc + 1;
      end
    end

    for (int k = 0; k < N_REQ; k++) begin
      if (bus.o_req_ready[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      if (rq[k].size() > 0) begin
        req_valid_v[k]       = 1'b1;
        req_byte_v[8*k +: 8] = rq[k][0].byt;
        req_last_v[k]        = rq[k][0].last;
      end else begin
        req_valid_v[k]       = 1'b0;
        req_byte_v[8*k +: 8] = 8'h00;
        req_last_v[k]        = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    int n;

    // Reset values while reset is held.
    wait_cycles(3);
    check_eq("rst_ready", 32'(bus.o_req_ready), 0);
    check_eq("rst_dv", 32'(bus.o_tx_dv), 0);
    check_eq("rst_byte", 32'(bus.o_tx_byte), 0);
    check_eq("rst_gid", 32'(bus.o_grant_id), 0);
    check_eq("rst_busy", 32'(bus.o_busy), 0);
    check_eq("rst_err", 32'(bus.o_err_timeout), 0);
    i_rst = 1'b0;
    wait_cycles(1);

    // Single byte from requester 0.
    push(0, 8'h55, 1'b1);
    wait_idle("single");
    check_eq("single_gid", 32'(bus.o_grant_id), 0);

    // Round robin over all four requesters.
    do_reset();
    push(0, 8'hA0, 1'b1);
    push(1, 8'hA1, 1'b1);
    push(2, 8'hA2, 1'b1);
    push(3, 8'hA3, 1'b1);
    push(0, 8'hA4, 1'b1);
    d0 = dv_cnt;
    wait_idle("rr");
    check_eq("rr_dv_count", 32'(dv_cnt - d0), 5);
    check_eq("rr_last_gid", 32'(bus.o_grant_id), 0);

    // Frame lock: requester 1 keeps the TX for a three-byte frame while 2 waits.
    do_reset();
    e0 = err_cnt;
    push(1, 8'h10, 1'b0);
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    push(2, 8'h20, 1'b1);
    wait_idle("lock");
    check_eq("lock_last_gid", 32'(bus.o_grant_id), 2);
    check_eq("lock_no_timeout", 32'(err_cnt - e0), 0);

    // Hold timeout: requester 3 leaves a frame open, requester 0 waits behind the lock.
    do_reset();
    e0 = err_cnt;
    push(3, 8'h33, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      wait_cycles(1);
      n++;
    end
    check_eq("tmo_first_dv", 32'(n < 100), 1);
    push(0, 8'h44, 1'b1);
    wait_idle("tmo");
    check_eq("tmo_err_count", 32'(err_cnt - e0), 1);
    check_eq("tmo_err_gap", 32'(err_gap), HT);
    check_eq("tmo_grant_after_err", 32'(last_dv_cyc - err_cyc), 1);

    // Busy guard: transmitter active blocks any grant.
    do_reset();
    force_active = 1'b1;
    d0 = dv_cnt;
    push(0, 8'h66, 1'b1);
    wait_cycles(10);
    check_eq("guard_no_dv", 32'(dv_cnt - d0), 0);
    check_eq("guard_busy", 32'(bus.o_busy), 0);
    force_active = 1'b0;
    wait_idle("guard");
    check_eq("guard_dv_after", 32'(dv_cnt - d0), 1);

    // Reset while waiting for tx_done, then a stale done.
    do_reset();
    tx_auto = 1'b0;
    d0 = dv_cnt;
    push(1, 8'h77, 1'b0);
    n = 0;
    while (dv_cnt == d0 && n < 100) begin
      wait_cycles(1);
      n++;
    end
    check_eq("mid_dv_seen", 32'(n < 100), 1);
    i_rst = 1'b1;
    wait_cycles(1);
    check_eq("mid_rst_ready", 32'(bus.o_req_ready), 0);
    check_eq("mid_rst_dv", 32'(bus.o_tx_dv), 0);
    check_eq("mid_rst_byte", 32'(bus.o_tx_byte), 0);
    check_eq("mid_rst_gid", 32'(bus.o_grant_id), 0);
    check_eq("mid_rst_busy", 32'(bus.o_busy), 0);
    check_eq("mid_rst_err", 32'(bus.o_err_timeout), 0);
    i_rst = 1'b0;
    d0 = dv_cnt;
    man_done = 1'b1;
    wait_cycles(1);
    man_done = 1'b0;
    wait_cycles(5);
    check_eq("stale_done_busy", 32'(bus.o_busy), 0);
    check_eq("stale_done_gid", 32'(bus.o_grant_id), 0);
    check_eq("stale_done_no_dv", 32'(dv_cnt - d0), 0);
    tx_auto = 1'b1;

    check_eq("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requester ports (2..8).
REQ-002 Parameter HOLD_TIMEOUT, default 1024, idle cycles before a frame lock is forcibly released (0 = never release).
REQ-003 i_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_req_valid  input  N_REQ  per-requester byte-valid.
REQ-006 i_req_byte  input  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 i_req_last  input  N_REQ  per-requester flag: this byte ends the frame.
REQ-008 o_req_ready  output  N_REQ  one-cycle accept pulse to the granted requester.
REQ-009 o_tx_dv  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 o_tx_byte  output  8  byte to transmit; valid while o_tx_dv is high.
REQ-011 i_tx_active  input  1  transmitter busy.
REQ-012 i_tx_done  input  1  one-cycle pulse from transmitter at end of stop bit.
REQ-013 o_grant_id  output  clog2(N_REQ)  index of the current or last granted requester.
REQ-014 o_busy  output  1  high in any state other than IDLE.
REQ-015 o_err_timeout  output  1  one-cycle pulse when a frame lock is released by timeout.

Function
REQ-016 States: IDLE, WAIT_DONE, HOLD. All outputs are registered.
REQ-017 IDLE, any i_req_valid high and i_tx_active low: pick the winner round-robin, searching from (ptr+1) mod N_REQ upward with wrap.
REQ-018 On that same edge, set o_req_ready[winner]=1 and o_tx_dv=1, load o_tx_byte from the winner's byte, set o_grant_id=winner, set ptr=winner, capture the winner's i_req_last, and go to WAIT_DONE.
REQ-019 o_req_ready and o_tx_dv are high for exactly one cycle, the cycle after the grant edge. Never more than one o_req_ready bit is high.
REQ-020 Handshake: a requester holds valid, byte and last stable until it sees its ready. The transfer counts as complete in the ready cycle.
REQ-021 IDLE with i_tx_active high: issue no grant and stay in IDLE.
REQ-022 WAIT_DONE: wait for i_tx_done. On i_tx_done, go to IDLE if the captured last = 1; otherwise go to HOLD and clear the timeout counter.
REQ-023 HOLD (frame lock): only requester o_grant_id may be granted; all other valids are ignored.
REQ-024 HOLD, the locked requester's valid high: grant it as in REQ-018 (ptr unchanged) and go to WAIT_DONE.
REQ-025 HOLD, the locked requester's valid low: increment the timeout counter. When it reaches HOLD_TIMEOUT (nonzero), pulse o_err_timeout and go to IDLE.
REQ-026 Minimum gap between consecutive o_tx_dv pulses: one cycle after i_tx_done. The next dv is never issued in the same cycle as i_tx_done.
REQ-027 i_tx_done outside WAIT_DONE is ignored.
REQ-028 Valid deasserted by a requester that is not granted has no effect. A requester may not withdraw valid after being granted; behaviour in that case is undefined.

Reset
REQ-029 When i_rst is high at a clock edge:
- state = IDLE; ptr = N_REQ-1, so requester 0 has first priority.
- o_req_ready = 0, o_tx_dv = 0, o_tx_byte = 0, o_grant_id = 0, o_busy = 0, o_err_timeout = 0; timeout counter = 0.
REQ-030 Reset mid-transfer (WAIT_DONE or HOLD) abandons the lock. A later i_tx_done from the in-flight byte is ignored per REQ-027.

Verification
REQ-031 Single byte: req0 valid, byte 0x55, last=1 -> one-cycle ready[0] and tx_dv with tx_byte=0x55. The arbiter stays in WAIT_DONE until done, then returns to IDLE.
REQ-032 Round-robin, all four valid with last=1 and bytes 0xA0..0xA3 -> grants in order 0,1,2,3,0. Exactly one dv per done.
REQ-033 Frame lock: req1 sends 0x10, 0x11, 0x12 (last on 0x12) while req2 is valid -> all three bytes from req1 go out consecutively, then req2 is granted.
REQ-034 Timeout, HOLD_TIMEOUT=8: req3 sends 0x33 with last=0 then drops valid, req0 valid -> o_err_timeout pulses 8 cycles after done, then req0 is granted.
REQ-035 Busy guard and reset: i_tx_active=1 with req0 valid -> no dv. Assert i_rst in WAIT_DONE -> all outputs 0 next cycle, and a following i_tx_done causes no grant change.
